dbu_param: RTL



---
 rtl/dbu_pkg.sv | 15 +
 rtl/dbu_param_if.sv | 39 +++
 rtl/dbu_debounce.sv | 47 ++++
 rtl/dbu_param.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dbu_pkg.sv
// Shared types for the parametrised debug unit: CPU gating states and the
// display channel that carries the memory/register-file read port.
package dbu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        BURST = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } state_e;

    localparam int SEL_MEMRF = 0;

endpackage

// File: rtl/dbu_param_if.sv
// Board/CPU-side signal bundle of the debug unit. The board or bench drives
// the master side; the debug unit sits on the slave side.
interface dbu_param_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int NCH     = 8,
    parameter int SEL_W   = 3,
    parameter int BURST_W = 8
);
    logic                  succ;
    logic                  step;
    logic                  inc;
    logic                  dec;
    logic                  m_rf;
    logic [SEL_W-1:0]      sel;
    logic [BURST_W-1:0]    burst_n;
    logic                  bp_en;
    logic [DATA_W-1:0]     bp_pc;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     m_data;
    logic [DATA_W-1:0]     rf_data;
    logic [NCH*DATA_W-1:0] status;
    logic                  run;
    logic [ADDR_W-1:0]     m_rf_addr;
    logic [DATA_W-1:0]     data_display;
    logic [7:0]            led;

    modport master (
        output succ, step, inc, dec, m_rf, sel, burst_n, bp_en, bp_pc, pc,
               m_data, rf_data, status,
        input  run, m_rf_addr, data_display, led
    );

    modport slave (
        input  succ, step, inc, dec, m_rf, sel, burst_n, bp_en, bp_pc, pc,
               m_data, rf_data, status,
        output run, m_rf_addr, data_display, led
    );
endinterface

// File: rtl/dbu_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for one raw board input;
// emits the debounced level and a one-cycle pulse on its rising edge.
module dbu_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             rise_r;

    // The level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r  <= 2'b00;
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], raw};
            if (sync_r[1] != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync_r[1];
                    rise_r  <= sync_r[1];
                    cnt_r   <= {CNT_W{1'b0}};
                end else begin
                    rise_r  <= 1'b0;
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
            end else begin
                rise_r <= 1'b0;
                cnt_r  <= {CNT_W{1'b0}};
            end
        end
    end

    assign level      = level_r;
    assign rise_pulse = rise_r;
endmodule

// File: rtl/dbu_param.sv
// Parametrised debug unit: conditions board inputs, gates the CPU clock enable
// (step / burst / run / breakpoint halt), walks the read address and muxes the display.
module dbu_param
    import dbu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int RF_AW      = 5,
    parameter int NCH        = 8,
    parameter int SEL_W      = 3,
    parameter int BURST_W    = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    dbu_param_if.slave  bus
);
    localparam logic [ADDR_W-1:0] RF_MASK  = ADDR_W'((64'd1 << RF_AW) - 64'd1);
    localparam logic [ADDR_W-1:0] MEM_MASK = {ADDR_W{1'b1}};
    localparam logic [SEL_W:0]    NCH_L    = (SEL_W+1)'(NCH);

    logic succ_lvl_s, succ_rise_s, step_lvl_s, step_pulse_s;
    logic inc_lvl_s, inc_pulse_s, dec_lvl_s, dec_pulse_s, m_rf_lvl_s, m_rf_rise_s;

    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_succ (.clk(clk), .rst(rst), .raw(bus.succ), .level(succ_lvl_s), .rise_pulse(succ_rise_s));
    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (.clk(clk), .rst(rst), .raw(bus.step), .level(step_lvl_s), .rise_pulse(step_pulse_s));
    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc  (.clk(clk), .rst(rst), .raw(bus.inc),  .level(inc_lvl_s),  .rise_pulse(inc_pulse_s));
    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec  (.clk(clk), .rst(rst), .raw(bus.dec),  .level(dec_lvl_s),  .rise_pulse(dec_pulse_s));
    dbu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mrf  (.clk(clk), .rst(rst), .raw(bus.m_rf), .level(m_rf_lvl_s), .rise_pulse(m_rf_rise_s));

    state_e             state_r, state_nxt_s;
    logic [BURST_W-1:0] cnt_r, cnt_nxt_s;
    logic               run_r, run_nxt_s;
    logic               bp_hit_s;
    logic [ADDR_W-1:0]  addr_r, addr_nxt_s, addr_mask_s;
    logic               m_rf_d_r;
    logic [DATA_W-1:0]  ch_s [NCH];
    logic [DATA_W-1:0]  disp_r, disp_nxt_s;
    logic [7:0]         led_r;
    logic [ADDR_W+5:0]  addr_ext_s;
    logic               unused_s;

    assign bp_hit_s = bus.bp_en && (bus.pc == bus.bp_pc);

    // Next state and the run enable for the coming cycle; a breakpoint match
    // clears run before it reaches the register, so that instruction never issues.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        run_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (succ_lvl_s) begin
                    state_nxt_s = RUN;
                    run_nxt_s   = 1'b1;
                end else if (step_pulse_s) begin
                    run_nxt_s = 1'b1;
                    if (bus.burst_n <= BURST_W'(1)) begin
                        state_nxt_s = STEP;
                    end else begin
                        state_nxt_s = BURST;
                        cnt_nxt_s   = bus.burst_n - BURST_W'(1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STEP: begin
                state_nxt_s = IDLE;
            end
            BURST: begin
                if (cnt_r == {BURST_W{1'b0}}) begin
                    state_nxt_s = IDLE;
                end else if (bp_hit_s) begin
                    state_nxt_s = HALT;
                    cnt_nxt_s   = {BURST_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r - BURST_W'(1);
                    run_nxt_s = 1'b1;
                end
            end
            RUN: begin
                if (!succ_lvl_s) begin
                    state_nxt_s = IDLE;
                end else if (bp_hit_s) begin
                    state_nxt_s = HALT;
                end else begin
                    run_nxt_s = 1'b1;
                end
            end
            HALT: begin
                if (!succ_lvl_s) begin
                    state_nxt_s = IDLE;
                end else if (step_pulse_s) begin
                    run_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {BURST_W{1'b0}};
            end
        endcase
    end

    // FSM state, burst counter and the registered CPU clock enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {BURST_W{1'b0}};
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            run_r   <= run_nxt_s;
        end
    end

    // Address walk: a mode flip restarts at 0; opposing pulses cancel.
    always_comb begin
        addr_mask_s = m_rf_lvl_s ? MEM_MASK : RF_MASK;
        if (m_rf_lvl_s != m_rf_d_r) begin
            addr_nxt_s = {ADDR_W{1'b0}};
        end else if (inc_pulse_s && !dec_pulse_s) begin
            addr_nxt_s = (addr_r + ADDR_W'(1)) & addr_mask_s;
        end else if (dec_pulse_s && !inc_pulse_s) begin
            addr_nxt_s = (addr_r - ADDR_W'(1)) & addr_mask_s;
        end else begin
            addr_nxt_s = addr_r;
        end
    end

    // Read address and the previous debounced mode used for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r   <= {ADDR_W{1'b0}};
            m_rf_d_r <= 1'b0;
        end else begin
            addr_r   <= addr_nxt_s;
            m_rf_d_r <= m_rf_lvl_s;
        end
    end

    // Channel table; selects past the last channel show zero.
    always_comb begin
        ch_s[SEL_MEMRF] = m_rf_lvl_s ? bus.m_data : bus.rf_data;
        for (int k = 1; k < NCH; k++) begin
            ch_s[k] = bus.status[k*DATA_W +: DATA_W];
        end
        if ({1'b0, bus.sel} < NCH_L) begin
            disp_nxt_s = ch_s[bus.sel];
        end else begin
            disp_nxt_s = {DATA_W{1'b0}};
        end
    end

    assign addr_ext_s = {6'd0, addr_r};

    // Display and LED registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_r <= {DATA_W{1'b0}};
            led_r  <= 8'h00;
        end else begin
            disp_r <= disp_nxt_s;
            led_r  <= {(state_r == HALT), run_r, addr_ext_s[5:0]};
        end
    end

    assign bus.run          = run_r;
    assign bus.m_rf_addr    = addr_r;
    assign bus.data_display = disp_r;
    assign bus.led          = led_r;

    assign unused_s = ^{succ_rise_s, step_lvl_s, inc_lvl_s, dec_lvl_s, m_rf_rise_s,
                        bus.status[DATA_W-1:0]};
endmodule
